// File: rtl/fwd_pkg.sv
// Shared types and select codes for the EX-operand forwarding controller.
// Stage entries record what an in-flight instruction will write back.
package fwd_pkg;

    localparam int RA_W = 5;

    localparam logic [2:0] SEL_RF  = 3'b000;
    localparam logic [2:0] SEL_MEM = 3'b001;
    localparam logic [2:0] SEL_WB  = 3'b010;
    localparam logic [2:0] SEL_RET = 3'b011;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;
    localparam int STG_RET = 3;
    localparam int STG_N   = 4;

    typedef struct packed {
        logic            valid;
        logic            we;
        logic            load;
        logic [RA_W-1:0] rd;
    } stage_ent_t;

    // x0 is hardwired zero, so a write to it is never a forwarding source.
    function automatic logic is_match(input stage_ent_t s, input logic [RA_W-1:0] rs);
        return s.valid & s.we & (s.rd == rs) & (rs != '0);
    endfunction

endpackage

// File: rtl/fwd_src_pick.sv
// Priority encoder choosing one EX operand source from the in-flight stages.
// The youngest matching writer wins, since it holds the newest value.
module fwd_src_pick
    import fwd_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic [RA_W-1:0]  rs_i,
    input  stage_ent_t       ex_i,
    input  stage_ent_t       mem_i,
    input  stage_ent_t       wb_i,
    output logic [SEL_W-1:0] sel_o
);

    // Stage names are as seen from ID; one edge later each result sits one stage further on.
    always_comb begin
        sel_o = SEL_W'(SEL_RF);
        if (is_match(ex_i, rs_i)) begin
            sel_o = SEL_W'(SEL_MEM);
        end else if (is_match(mem_i, rs_i)) begin
            sel_o = SEL_W'(SEL_WB);
        end else if (is_match(wb_i, rs_i)) begin
            sel_o = SEL_W'(SEL_RET);
        end
    end

endmodule

// File: rtl/fwd_ctrl_unit.sv
// Forwarding / load-use hazard controller driving the EX operand mux selects.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module fwd_ctrl_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 3
`ifdef FWD_STATS_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_we_i,
    input  logic                  id_load_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic [SEL_W-1:0]      fwd_sel_a_o,
    output logic [SEL_W-1:0]      fwd_sel_b_o
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_W-1:0]      fwd_cnt_o,
    output logic [CNT_W-1:0]      stall_cnt_o
`endif
);

    stage_ent_t       stg_q [STG_N];
    stage_ent_t       stg_d [STG_N];
    logic [SEL_W-1:0] sel_a_q, sel_a_d;
    logic [SEL_W-1:0] sel_b_q, sel_b_d;
    logic [SEL_W-1:0] pick_a, pick_b;
    logic             stall;
    logic             issue;

    fwd_src_pick #(.SEL_W(SEL_W)) u_pick_a (
        .rs_i  (id_rs1_i),
        .ex_i  (stg_q[STG_EX]),
        .mem_i (stg_q[STG_MEM]),
        .wb_i  (stg_q[STG_WB]),
        .sel_o (pick_a)
    );

    fwd_src_pick #(.SEL_W(SEL_W)) u_pick_b (
        .rs_i  (id_rs2_i),
        .ex_i  (stg_q[STG_EX]),
        .mem_i (stg_q[STG_MEM]),
        .wb_i  (stg_q[STG_WB]),
        .sel_o (pick_b)
    );

    always_comb begin
        // rs2 is checked even for instrs that ignore it; a spurious stall only costs a cycle.
        stall = id_valid_i & ~flush_i
              & stg_q[STG_EX].valid & stg_q[STG_EX].load & stg_q[STG_EX].we
              & (stg_q[STG_EX].rd != '0)
              & ((stg_q[STG_EX].rd == id_rs1_i) | (stg_q[STG_EX].rd == id_rs2_i));
        issue = id_valid_i & ~flush_i & ~stall;

        stg_d[STG_EX] = '0;
        if (issue) begin
            stg_d[STG_EX].valid = 1'b1;
            stg_d[STG_EX].we    = id_we_i;
            stg_d[STG_EX].load  = id_load_i;
            stg_d[STG_EX].rd    = id_rd_i;
        end
        for (int i = 1; i < STG_N; i++) begin
            stg_d[i] = stg_q[i-1];
        end

        sel_a_d = issue ? pick_a : SEL_W'(SEL_RF);
        sel_b_d = issue ? pick_b : SEL_W'(SEL_RF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STG_N; i++) begin
                stg_q[i] <= '0;
            end
            sel_a_q <= SEL_W'(SEL_RF);
            sel_b_q <= SEL_W'(SEL_RF);
        end else begin
            for (int i = 0; i < STG_N; i++) begin
                stg_q[i] <= stg_d[i];
            end
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign stall_o     = stall;
    assign fwd_sel_a_o = sel_a_q;
    assign fwd_sel_b_o = sel_b_q;

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counted against the value being registered, so A and B can add up to 2 per edge.
    always_comb begin
        fwd_cnt_d   = fwd_cnt_q + CNT_W'(sel_a_d != '0) + CNT_W'(sel_b_d != '0);
        stall_cnt_d = stall_cnt_q + CNT_W'(stall);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_cnt_o   = fwd_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
